cmp_bit_serializer: RTL and testbench



---
 rtl/cordic_pkg.sv | 17 +
 rtl/cmp_bit_serializer_if.sv | 25 ++
 rtl/cmp_bit_serializer_bit_index_counter.sv | 38 +++
 rtl/cmp_bit_serializer.sv | 137 +++++++++++++
 tb/tb_cmp_bit_serializer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared types and sizes for the CORDIC comparison-channel serializer.
package cordic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int CORDIC_RES_W = 6;
    localparam int FRAME_CNT_W  = 8;

    // Bit-index width for a frame of w bits; a single-bit frame still needs one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/cmp_bit_serializer_if.sv
// Load handshake and bit-serial comparison link of the serializer.
interface cmp_bit_serializer_if
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_RES_W
);
    logic                   load_valid;
    logic [WIDTH-1:0]       load_data;
    logic                   load_ready;
    logic                   gt;
    logic                   lt;
    logic                   bit_valid;
    logic                   last;
    logic [FRAME_CNT_W-1:0] frames_sent;

    modport master (
        output load_valid, load_data,
        input  load_ready, gt, lt, bit_valid, last, frames_sent
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, gt, lt, bit_valid, last, frames_sent
    );
endinterface

// File: rtl/cmp_bit_serializer_bit_index_counter.sv
// Terminal-count bit index: clear restarts at 0, enable steps and wraps after WIDTH-1.
module bit_index_counter
    import cordic_pkg::*;
#(
    parameter  int WIDTH = CORDIC_RES_W,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] idx_r;

    // Index register with clear taking priority over counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (clr) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (en) begin
            if (idx_r == LAST_IDX) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    assign idx     = idx_r;
    assign at_last = (idx_r == LAST_IDX);
endmodule

// File: rtl/cmp_bit_serializer.sv
// Parallel-to-serial transmitter: one word per handshake, LSB first on the gt/lt pair.
module cmp_bit_serializer
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_RES_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    cmp_bit_serializer_if.slave  bus
);
    localparam int               IDX_W     = idx_width(WIDTH);
    localparam logic [IDX_W:0]   PRE_LAST  = (IDX_W + 1)'(WIDTH - 1);
    localparam logic             LOAD_LAST = (WIDTH == 1) ? 1'b1 : 1'b0;

    ser_state_e             state_r;
    logic [WIDTH-1:0]       sreg_r;
    logic                   load_ready_r;
    logic                   gt_r;
    logic                   lt_r;
    logic                   bit_valid_r;
    logic                   last_r;
    logic [FRAME_CNT_W-1:0] frames_r;

    logic [IDX_W-1:0]       idx_s;
    logic                   at_last_s;
    logic                   hs_s;
    logic                   clr_s;
    logic                   en_s;
    logic                   next_last_s;
    logic                   frame_done_s;

    // Handshake, counter control and look-ahead of the next bit's last flag.
    always_comb begin
        hs_s         = bus.load_valid && load_ready_r;
        clr_s        = hs_s;
        frame_done_s = (state_r == SHIFT) && at_last_s;
        next_last_s  = (({1'b0, idx_s} + {{IDX_W{1'b0}}, 1'b1}) == PRE_LAST);
        if (state_r == SHIFT && !hs_s) begin
            en_s = 1'b1;
        end else begin
            en_s = 1'b0;
        end
    end

    bit_index_counter #(.WIDTH(WIDTH)) u_idx (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (clr_s),
        .en      (en_s),
        .idx     (idx_s),
        .at_last (at_last_s)
    );

    // Frame FSM; the outputs are registered with the values of the bit shown next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            sreg_r       <= {WIDTH{1'b0}};
            load_ready_r <= 1'b1;
            gt_r         <= 1'b0;
            lt_r         <= 1'b0;
            bit_valid_r  <= 1'b0;
            last_r       <= 1'b0;
            frames_r     <= {FRAME_CNT_W{1'b0}};
        end else begin
            if (frame_done_s) begin
                frames_r <= frames_r + FRAME_CNT_W'(1);
            end else begin
                frames_r <= frames_r;
            end
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        state_r      <= SHIFT;
                        sreg_r       <= bus.load_data >> 1'b1;
                        gt_r         <= bus.load_data[0];
                        lt_r         <= ~bus.load_data[0];
                        bit_valid_r  <= 1'b1;
                        last_r       <= LOAD_LAST;
                        load_ready_r <= LOAD_LAST;
                    end else begin
                        state_r      <= IDLE;
                        sreg_r       <= sreg_r;
                        gt_r         <= 1'b0;
                        lt_r         <= 1'b0;
                        bit_valid_r  <= 1'b0;
                        last_r       <= 1'b0;
                        load_ready_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (hs_s) begin
                        state_r      <= SHIFT;
                        sreg_r       <= bus.load_data >> 1'b1;
                        gt_r         <= bus.load_data[0];
                        lt_r         <= ~bus.load_data[0];
                        bit_valid_r  <= 1'b1;
                        last_r       <= LOAD_LAST;
                        load_ready_r <= LOAD_LAST;
                    end else if (!at_last_s) begin
                        state_r      <= SHIFT;
                        sreg_r       <= sreg_r >> 1'b1;
                        gt_r         <= sreg_r[0];
                        lt_r         <= ~sreg_r[0];
                        bit_valid_r  <= 1'b1;
                        last_r       <= next_last_s;
                        load_ready_r <= next_last_s;
                    end else begin
                        state_r      <= IDLE;
                        sreg_r       <= sreg_r;
                        gt_r         <= 1'b0;
                        lt_r         <= 1'b0;
                        bit_valid_r  <= 1'b0;
                        last_r       <= 1'b0;
                        load_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    sreg_r       <= {WIDTH{1'b0}};
                    gt_r         <= 1'b0;
                    lt_r         <= 1'b0;
                    bit_valid_r  <= 1'b0;
                    last_r       <= 1'b0;
                    load_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_r;
    assign bus.gt          = gt_r;
    assign bus.lt          = lt_r;
    assign bus.bit_valid   = bit_valid_r;
    assign bus.last        = last_r;
    assign bus.frames_sent = frames_r;
endmodule

// File: tb/tb_cmp_bit_serializer.sv
// Randomized and directed bench for cmp_bit_serializer against a frame-level reference model.
module tb_cmp_bit_serializer;
    import cordic_pkg::*;

    localparam int W = CORDIC_RES_W;

    logic CLK = 1'b0;
    logic RST;
    logic RST1;

    always #5 CLK = ~CLK;

    cmp_bit_serializer_if #(.WIDTH(W)) bus ();
    cmp_bit_serializer_if #(.WIDTH(1)) bus1 ();

    cmp_bit_serializer #(.WIDTH(W)) dut  (.CLK(CLK), .RST(RST),  .bus(bus));
    cmp_bit_serializer #(.WIDTH(1)) dut1 (.CLK(CLK), .RST(RST1), .bus(bus1));

    int checks = 0;
    int passes = 0;

    // Reference: the frame being sent and which of its bits is on the link.
    bit             m_busy;
    logic [W-1:0]   m_word;
    int             m_pos;
    int             m_frames;
    logic [W-1:0]   send_q[$];

    logic [31:0]    gt_log;
    int             bv_run;
    int             bv_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst);
        logic         lv;
        logic [W-1:0] ld;
        bit           exp_ready;
        bit           exp_gt;
        lv = (send_q.size() > 0);
        ld = lv ? send_q[0] : W'($urandom);
        bus.load_valid = lv;
        bus.load_data  = ld;
        RST            = rst;
        @(negedge CLK);
        exp_ready = !m_busy || (m_pos == W - 1);
        exp_gt    = m_busy && m_word[m_pos];
        check("load_ready",  32'(bus.load_ready),  32'(exp_ready));
        check("bit_valid",   32'(bus.bit_valid),   32'(m_busy));
        check("gt",          32'(bus.gt),          32'(exp_gt));
        check("lt",          32'(bus.lt),          32'(m_busy && !exp_gt));
        check("last",        32'(bus.last),        32'(m_busy && (m_pos == W - 1)));
        check("frames_sent", 32'(bus.frames_sent), 32'(m_frames));
        check("gt_lt_excl",  32'(bus.gt & bus.lt), 32'd0);
        if (bus.bit_valid === 1'b1) begin
            gt_log = {gt_log[30:0], bus.gt};
            bv_run++;
            if (bv_run > bv_max) bv_max = bv_run;
        end else begin
            bv_run = 0;
        end
        @(posedge CLK);
        if (rst) begin
            m_busy   = 1'b0;
            m_pos    = 0;
            m_frames = 0;
        end else begin
            if (m_busy && m_pos == W - 1) m_frames = (m_frames + 1) % 256;
            if (lv && exp_ready) begin
                m_busy = 1'b1;
                m_word = ld;
                m_pos  = 0;
                void'(send_q.pop_front());
            end else if (m_busy && m_pos < W - 1) begin
                m_pos++;
            end else begin
                m_busy = 1'b0;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (send_q.size() > 0 && n < max_cycles) begin
            cycle(1'b0);
            n++;
        end
        if (send_q.size() > 0) begin
            check("drain_timeout", 32'(send_q.size()), 32'd0);
            send_q.delete();
        end
    endtask

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus1.load_valid = 1'b0;
        bus1.load_data  = 1'b0;
        RST  = 1'b1;
        RST1 = 1'b1;
        m_busy = 1'b0; m_word = '0; m_pos = 0; m_frames = 0;
        gt_log = 32'd0; bv_run = 0; bv_max = 0;
        @(posedge CLK); #1;

        // Reset state, then a single frame.
        cycle(1'b1);
        gt_log = 32'd0;
        send_q.push_back(6'b101101);
        run(8);
        check("single_gt_seq", gt_log, 32'h2D);
        check("single_frames", 32'(bus.frames_sent), 32'd1);

        // Back-to-back frames with load_valid held.
        gt_log = 32'd0; bv_max = 0;
        send_q.push_back(6'b000001);
        send_q.push_back(6'b111110);
        run(14);
        check("b2b_gt_seq", gt_log & 32'hFFF, 32'h81F);
        check("b2b_bv_run", 32'(bv_max), 32'd12);
        check("b2b_frames", 32'(bus.frames_sent), 32'd3);

        // Word offered mid-frame waits for the last cycle.
        send_q.push_back(6'b100110);
        run(3);
        send_q.push_back(6'b111111);
        run(1);
        check("midframe_not_taken", 32'(send_q.size()), 32'd1);
        run(4);
        check("midframe_taken", 32'(send_q.size()), 32'd0);
        run(7);
        check("midframe_frames", 32'(bus.frames_sent), 32'd5);

        // Reset at bit 3 aborts the frame.
        send_q.push_back(6'b011010);
        run(4);
        cycle(1'b1);
        check("abort_frames", 32'(bus.frames_sent), 32'd0);
        check("abort_ready",  32'(bus.load_ready),  32'd1);
        send_q.push_back(6'b000111);
        run(8);
        check("restart_frames", 32'(bus.frames_sent), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (send_q.size() == 0 && $urandom_range(0, 2) == 0) send_q.push_back(W'($urandom));
            cycle($urandom_range(0, 99) == 0);
        end
        drain(100);
        run(7);

        // 256 frames wrap the frame counter.
        cycle(1'b1);
        for (int i = 0; i < 256; i++) send_q.push_back(6'b010101);
        drain(2000);
        run(7);
        check("wrap_frames", 32'(bus.frames_sent), 32'd0);

        // Single-bit frames.
        @(negedge CLK);
        check("w1_reset_ready", 32'(bus1.load_ready), 32'd1);
        check("w1_reset_gt",    32'(bus1.gt),         32'd0);
        @(posedge CLK); #1;
        RST1 = 1'b0;
        bus1.load_valid = 1'b1;
        bus1.load_data  = 1'b1;
        @(posedge CLK); #1;
        bus1.load_valid = 1'b0;
        @(negedge CLK);
        check("w1_gt",        32'(bus1.gt),         32'd1);
        check("w1_lt",        32'(bus1.lt),         32'd0);
        check("w1_last",      32'(bus1.last),       32'd1);
        check("w1_bit_valid", 32'(bus1.bit_valid),  32'd1);
        check("w1_ready",     32'(bus1.load_ready), 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("w1_idle_bv",   32'(bus1.bit_valid),   32'd0);
        check("w1_frames",    32'(bus1.frames_sent), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
